// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants and mode encoding for the zero-suppress compressor
package cmp_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_DATA   = 8;

   // Occupancy counter must reach 3*NUM_DATA inclusive
   function automatic int occ_width(input int num_data);
      return $clog2(3 * num_data + 1);
   endfunction

   localparam int DEF_OCC_W = occ_width(DEF_NUM_DATA);

   typedef enum logic {
      MODE_BYPASS   = 1'b0,
      MODE_COMPRESS = 1'b1
   } mode_e;

endpackage

// File: rtl/cmp_word_buffer.sv
// rtl/cmp_word_buffer.sv - 3*NUM_DATA word FIFO with variable push/pop counts, head kept at entry 0
module cmp_word_buffer
   import cmp_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int NUM_DATA   = DEF_NUM_DATA,
   localparam int OCC_W      = occ_width(NUM_DATA)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [OCC_W-1:0]                     push_cnt,
   input  logic [NUM_DATA:0][DATA_WIDTH-1:0]    push_words,
   input  logic [OCC_W-1:0]                     pop_cnt,
   output logic [OCC_W-1:0]                     occ,
   output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  head
);

   localparam int DEPTH = 3 * NUM_DATA;
   localparam int AW    = OCC_W + 1;
   localparam int IW    = $clog2(DEPTH);
   localparam int PW    = $clog2(NUM_DATA + 1);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
   logic [OCC_W-1:0]                 occ_q, occ_d;
   logic [AW-1:0]                    kept, jj, src, k;

   // Drop popped words, slide survivors to entry 0, append pushed words; unused entries stay zero
   always_comb begin
      occ_d = occ_q - pop_cnt + push_cnt;
      kept  = AW'(occ_q) - AW'(pop_cnt);
      jj    = '0;
      src   = '0;
      k     = '0;
      mem_d = '0;
      for (int j = 0; j < DEPTH; j++) begin
         jj  = AW'(j);
         src = jj + AW'(pop_cnt);
         k   = jj - kept;
         if (jj < kept) begin
            mem_d[j] = mem_q[IW'(src)];
         end else if (k < AW'(push_cnt)) begin
            mem_d[j] = push_words[PW'(k)];
         end
      end
   end

   // Storage and occupancy registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q <= '0;
         occ_q <= '0;
      end else begin
         mem_q <= mem_d;
         occ_q <= occ_d;
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[NUM_DATA-1:0];

endmodule

// File: rtl/zero_suppress_compressor.sv
// rtl/zero_suppress_compressor.sv - zero-lane suppression with mask word, packed into fixed-width output beats
module zero_suppress_compressor
   import cmp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_DATA   = DEF_NUM_DATA
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wrt_en,
   input  logic [DATA_WIDTH*NUM_DATA-1:0] data_in,
   input  logic                           tvalid_in,
   input  logic                           tlast_in,
   input  logic                           tready_in,
   output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
   output logic                           tready_out,
   output logic                           tvalid_out,
   output logic                           tlast_out
);

   localparam int               OCC_W = occ_width(NUM_DATA);
   localparam int               PW    = $clog2(NUM_DATA + 1);
   localparam logic [OCC_W-1:0] N_OCC = OCC_W'(NUM_DATA);
   localparam logic [OCC_W-1:0] TWO_N = OCC_W'(2 * NUM_DATA);

   logic [OCC_W-1:0]                    occ, push_cnt, pop_cnt, nz_cnt;
   logic [NUM_DATA:0][DATA_WIDTH-1:0]   push_words;
   logic [NUM_DATA-1:0][DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0]               mask_word;
   logic                                flush_q, flush_d;
   logic                                pkt_start_q, pkt_start_d;
   mode_e                               mode_q, mode_d, beat_mode;
   logic                                accept, pop;

   assign tready_out = (occ < TWO_N) && !flush_q;
   assign tvalid_out = (occ >= N_OCC) || (flush_q && (occ != '0));
   assign tlast_out  = flush_q && (occ <= N_OCC);
   assign accept     = tvalid_in && tready_out;
   assign pop        = tvalid_out && tready_in;
   assign pop_cnt    = pop ? ((occ < N_OCC) ? occ : N_OCC) : '0;
   assign data_out   = head;

   // Build the words one accepted beat contributes: mask + nonzero lanes, or all lanes in bypass
   always_comb begin
      beat_mode  = pkt_start_q ? (wrt_en ? MODE_COMPRESS : MODE_BYPASS) : mode_q;
      mask_word  = '0;
      push_words = '0;
      push_cnt   = '0;
      nz_cnt     = '0;
      for (int i = 0; i < NUM_DATA; i++) begin
         mask_word[i] = |data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (accept) begin
         if (beat_mode == MODE_COMPRESS) begin
            push_words[0] = mask_word;
            nz_cnt        = OCC_W'(1);
            for (int i = 0; i < NUM_DATA; i++) begin
               if (mask_word[i]) begin
                  push_words[PW'(nz_cnt)] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                  nz_cnt                  = nz_cnt + OCC_W'(1);
               end
            end
            push_cnt = nz_cnt;
         end else begin
            for (int i = 0; i < NUM_DATA; i++) begin
               push_words[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            push_cnt = N_OCC;
         end
      end
   end

   // Packet tracking: mode latches on the first beat, tlast arms the flush, emptying pop disarms it
   always_comb begin
      flush_d     = flush_q;
      pkt_start_d = pkt_start_q;
      mode_d      = mode_q;
      if (pop && (occ <= N_OCC)) begin
         flush_d = 1'b0;
      end
      if (accept) begin
         if (tlast_in) begin
            flush_d = 1'b1;
         end
         mode_d      = beat_mode;
         pkt_start_d = tlast_in;
      end
   end

   // Packet tracking registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flush_q     <= 1'b0;
         pkt_start_q <= 1'b1;
         mode_q      <= MODE_BYPASS;
      end else begin
         flush_q     <= flush_d;
         pkt_start_q <= pkt_start_d;
         mode_q      <= mode_d;
      end
   end

   cmp_word_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_DATA   (NUM_DATA)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push_cnt   (push_cnt),
      .push_words (push_words),
      .pop_cnt    (pop_cnt),
      .occ        (occ),
      .head       (head)
   );

endmodule

// File: doc/zero_suppress_compressor.md
ZERO_SUPPRESS_COMPRESSOR -- requirements
Module: zero_suppress_compressor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one data word in bits.
REQ-002 SHALL have parameter NUM_DATA, default 8, meaning words per beat; legal range 2..16 and NUM_DATA <= DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wrt_en  input  1  compress enable (1 = compress, 0 = bypass), sampled on the first accepted beat of each packet.
REQ-006 SHALL have port data_in  input  DATA_WIDTH*NUM_DATA  input beat; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port tvalid_in  input  1  input beat valid.
REQ-008 SHALL have port tlast_in  input  1  input beat is the last beat of its packet.
REQ-009 SHALL have port tready_in  input  1  downstream ready.
REQ-010 SHALL have port data_out  output  DATA_WIDTH*NUM_DATA  output beat, same lane order as data_in.
REQ-011 SHALL have port tready_out  output  1  block accepts an input beat.
REQ-012 SHALL have port tvalid_out  output  1  output beat valid.
REQ-013 SHALL have port tlast_out  output  1  output beat is the last beat of its packet.

Function
REQ-014 SHALL transfer an input beat when tvalid_in && tready_out at a rising edge, and an output beat when tvalid_out && tready_in at a rising edge.
REQ-015 In compress mode, each accepted beat SHALL append to the word stream one mask word (bit i = 1 iff lane i != 0; upper bits 0), followed by the nonzero lanes in ascending lane order.
REQ-016 In bypass mode, each accepted beat SHALL append its NUM_DATA lanes unchanged, with no mask word.
REQ-017 SHALL buffer the word stream in a 3*NUM_DATA-word FIFO with occupancy counter occ, where lane 0 of data_out = oldest word.
REQ-018 tready_out SHALL equal (occ <= 2*NUM_DATA-1) && !flush_pending, computed from registered state only.
REQ-019 tvalid_out SHALL equal (occ >= NUM_DATA) || (flush_pending && occ > 0).
REQ-020 On pop, the block SHALL remove min(occ, NUM_DATA) words; lanes beyond occ SHALL read 0 (zero padding).
REQ-021 Accepting a beat with tlast_in = 1 SHALL set flush_pending; the pop that empties the FIFO SHALL clear it.
REQ-022 tlast_out SHALL equal flush_pending && occ <= NUM_DATA.
REQ-023 A push and a pop in the same cycle SHALL both take effect: occ_next = occ + pushed - popped.
REQ-024 A word accepted at edge k SHALL be visible on data_out from edge k onward (1-cycle latency); there is no combinational input-to-output path.
REQ-025 While tvalid_out && !tready_in, data_out, tvalid_out and tlast_out SHALL hold stable.
REQ-026 Mode SHALL latch on the first beat after reset or after a tlast beat, and hold for the rest of the packet.

Reset
REQ-027 reset low SHALL immediately clear occ, flush_pending, the mode latch and the packet-start flag, drive data_out = 0, tvalid_out = 0 and tlast_out = 0, and drive tready_out = 1 after release.
REQ-028 Reset asserted mid-packet SHALL discard all buffered words; the first beat after release starts a new packet.

Structure
REQ-029 Package cmp_pkg SHALL hold DATA_WIDTH/NUM_DATA defaults, the occupancy-width constant $clog2(3*NUM_DATA+1), and the mode encoding.
REQ-030 The FIFO/packing logic SHALL be sub-module cmp_word_buffer (variable push count 0..NUM_DATA+1, pop count 0..NUM_DATA); mask generation and lane compaction SHALL stay in the top level.

Verification (DATA_WIDTH=32, NUM_DATA=8)
REQ-031 Single beat, lane1=0xAAAA0001, lane4=0x00000006, other lanes 0, tlast_in=1 -> one output beat, lanes {0x12, 0xAAAA0001, 0x6, 0,0,0,0,0}, tlast_out=1.
REQ-032 Two beats, all lanes 0xBA98FEDC, tlast on the second (18 words) -> 3 output beats; beat 1 lane0=0xFF, beat 2 lane1=0xFF, beat 3 lanes0-1=0xBA98FEDC with the rest 0, tlast_out only on beat 3.
REQ-033 wrt_en=0, two beats, tlast on the second -> two output beats identical to the input, tlast_out on beat 2, each valid 1 cycle after acceptance.
REQ-034 Continuous all-nonzero input with tready_in=0 for 10 cycles -> tready_out falls once occ > 15, data_out stable, no word lost or duplicated after tready_in returns to 1.
REQ-035 All-zero beat with tlast_in=1 -> one beat, all lanes 0 (mask 0x0), tlast_out=1.
REQ-036 reset low mid-packet with occ=12 -> tvalid_out=0 and data_out=0 immediately; the packet after release matches REQ-031.
